// File: rtl/axi_cache_master_port.sv
// rtl/axi_cache_master_port.sv - single-outstanding AXI4 master port for one L1 cache
// Handles line refill, single-beat write-through and full-line write-back.
module axi_cache_master_port #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int ID_W       = 4,
  parameter int ID_VAL     = 0,
  parameter int LINE_WORDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic                req_line,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W/8-1:0] req_strb,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                wr_pop,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  output logic                rd_last,
  output logic                done,
  output logic                err,
  output logic [ID_W-1:0]     ARID,
  output logic [ADDR_W-1:0]   ARADDR,
  output logic [7:0]          ARLEN,
  output logic [2:0]          ARSIZE,
  output logic [1:0]          ARBURST,
  output logic                ARVALID,
  input  logic                ARREADY,
  input  logic [ID_W-1:0]     RID,
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP,
  input  logic                RLAST,
  input  logic                RVALID,
  output logic                RREADY,
  output logic [ID_W-1:0]     AWID,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic [7:0]          AWLEN,
  output logic [2:0]          AWSIZE,
  output logic [1:0]          AWBURST,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  output logic                WLAST,
  output logic                WVALID,
  input  logic                WREADY,
  input  logic [ID_W-1:0]     BID,
  input  logic [1:0]          BRESP,
  input  logic                BVALID,
  output logic                BREADY
);

  localparam int STRB_W     = DATA_W / 8;
  localparam int CNT_W      = $clog2(LINE_WORDS) + 1;
  localparam int LINE_BYTES = LINE_WORDS * STRB_W;
  localparam logic [ADDR_W-1:0] LINE_MASK = ~(ADDR_W'(LINE_BYTES - 1));
  localparam logic [ADDR_W-1:0] WORD_MASK = ~(ADDR_W'(STRB_W - 1));
  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [7:0]        LINE_LEN  = 8'(LINE_WORDS - 1);
  localparam logic [2:0]        BEAT_SIZE = 3'($clog2(STRB_W));

  typedef enum logic [2:0] {IDLE, AR, R, AW, W, B} state_t;

  state_t              state, next_state;
  logic [ADDR_W-1:0]   addr_q;
  logic                line_q;
  logic [STRB_W-1:0]   strb_q;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_inc;
  logic [CNT_W-1:0]    w_last_idx;
  logic                err_acc;
  logic                done_q, err_q;
  logic                accept, rd_hs, wr_hs, b_hs;
  logic                beat_err;

  // Response IDs are not checked: only one transaction is ever in flight.
  wire unused_ids = &{1'b0, RID, BID};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    ARVALID    = 1'b0;
    RREADY     = 1'b0;
    AWVALID    = 1'b0;
    WVALID     = 1'b0;
    BREADY     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) next_state = req_write ? AW : AR;
      end
      AR: begin
        ARVALID = 1'b1;
        if (ARREADY) next_state = R;
      end
      R: begin
        RREADY = 1'b1;
        if (RVALID && RLAST) next_state = IDLE;
      end
      AW: begin
        AWVALID = 1'b1;
        if (AWREADY) next_state = W;
      end
      W: begin
        WVALID = 1'b1;
        if (WREADY && (cnt == w_last_idx)) next_state = B;
      end
      B: begin
        BREADY = 1'b1;
        if (BVALID) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign accept     = req_valid && req_ready;
  assign rd_hs      = RVALID && RREADY;
  assign wr_hs      = WVALID && WREADY;
  assign b_hs       = BVALID && BREADY;
  assign cnt_inc    = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  assign w_last_idx = line_q ? LAST_IDX : '0;

  // A non-last beat at the line's last index is an overrun; RLAST elsewhere is a short/long burst.
  assign beat_err = (RRESP != 2'b00) || (RLAST ? (cnt != LAST_IDX) : (cnt == LAST_IDX));

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      line_q  <= 1'b0;
      strb_q  <= '0;
      cnt     <= '0;
      err_acc <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (accept) begin
        addr_q  <= req_addr;
        line_q  <= req_line;
        strb_q  <= req_strb;
        cnt     <= '0;
        err_acc <= 1'b0;
      end
      if (rd_hs) begin
        cnt <= cnt_inc;
        if (RLAST) begin
          done_q <= 1'b1;
          err_q  <= err_acc || beat_err;
        end else begin
          err_acc <= err_acc || beat_err;
        end
      end
      if (wr_hs) cnt <= cnt_inc;
      if (b_hs) begin
        done_q <= 1'b1;
        err_q  <= (BRESP != 2'b00);
      end
    end
  end

  assign done     = done_q;
  assign err      = err_q;
  assign rd_data  = RDATA;
  assign rd_valid = rd_hs;
  assign rd_last  = rd_hs && RLAST;
  assign wr_pop   = wr_hs;

  assign ARID    = ID_W'(ID_VAL);
  assign ARADDR  = addr_q & LINE_MASK;
  assign ARLEN   = LINE_LEN;
  assign ARSIZE  = BEAT_SIZE;
  assign ARBURST = 2'b01;

  assign AWID    = ID_W'(ID_VAL);
  assign AWADDR  = addr_q & (line_q ? LINE_MASK : WORD_MASK);
  assign AWLEN   = line_q ? LINE_LEN : 8'd0;
  assign AWSIZE  = BEAT_SIZE;
  assign AWBURST = 2'b01;

  assign WDATA = wr_data;
  assign WSTRB = line_q ? {STRB_W{1'b1}} : strb_q;
  assign WLAST = WVALID && (cnt == w_last_idx);

endmodule

// File: tb/tb_axi_cache_master_port.sv
// tb/tb_axi_cache_master_port.sv - directed self-checking bench for axi_cache_master_port
module tb_axi_cache_master_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_line;
  logic [31:0] req_addr;
  logic [3:0]  req_strb;
  logic [31:0] wr_data;
  logic        wr_pop;
  logic [31:0] rd_data;
  logic        rd_valid, rd_last, done, err;
  logic [3:0]  ARID, RID, AWID, BID;
  logic [31:0] ARADDR, AWADDR, RDATA, WDATA;
  logic [7:0]  ARLEN, AWLEN;
  logic [2:0]  ARSIZE, AWSIZE;
  logic [1:0]  ARBURST, AWBURST, RRESP, BRESP;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic        AWVALID, AWREADY;
  logic [3:0]  WSTRB;
  logic        WLAST, WVALID, WREADY, BVALID, BREADY;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  axi_cache_master_port #(
    .ADDR_W(32), .DATA_W(32), .ID_W(4), .ID_VAL(0), .LINE_WORDS(4)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_line(req_line), .req_addr(req_addr), .req_strb(req_strb),
    .wr_data(wr_data), .wr_pop(wr_pop),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
    .done(done), .err(err),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .RVALID(RVALID), .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID),
    .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  // Bus driver for a refill; starts and ends just after a falling edge, ends on the done cycle.
  task automatic run_refill(input logic [31:0] addr, input int nbeats, input int bad_beat,
                            input int ar_delay, output logic acc_rdy, output logic [31:0] araddr,
                            output logic [7:0] arlen, output logic [2:0] arsize,
                            output int arv_cycles, output int rd_cnt, output int last_at,
                            output int data_ok, output logic dn, output logic er);
    rd_cnt = 0; last_at = 0; data_ok = 0; arv_cycles = 0;
    req_valid = 1'b1; req_write = 1'b0; req_line = 1'b0; req_addr = addr;
    #1 acc_rdy = req_ready;
    @(negedge clk);
    req_valid = 1'b0;
    araddr = ARADDR; arlen = ARLEN; arsize = ARSIZE;
    repeat (ar_delay) begin
      if (ARVALID === 1'b1) arv_cycles++;
      @(negedge clk);
    end
    if (ARVALID === 1'b1) arv_cycles++;
    ARREADY = 1'b1;
    @(negedge clk);
    ARREADY = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      RVALID = 1'b1; RDATA = 32'hD000_0000 + b; RLAST = (b == nbeats - 1);
      RRESP = (b == bad_beat) ? 2'b10 : 2'b00;
      #1;
      if (rd_valid === 1'b1) rd_cnt++;
      if (rd_last === 1'b1) last_at = b + 1;
      if (rd_data === 32'hD000_0000 + b) data_ok++;
      @(negedge clk);
    end
    RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
    dn = done; er = err;
  endtask

  task automatic run_write(input logic [31:0] addr, input logic line, input logic [3:0] strb,
                           input int nbeats, input int w_delay, input logic [1:0] bresp,
                           output logic [31:0] awaddr, output logic [7:0] awlen,
                           output int pops, output logic [7:0] wlast_mask,
                           output logic [3:0] wstrb0, output int data_ok,
                           output logic early_w, output logic dn, output logic er);
    pops = 0; wlast_mask = '0; data_ok = 0; early_w = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_line = line; req_addr = addr; req_strb = strb;
    @(negedge clk);
    req_valid = 1'b0;
    awaddr = AWADDR; awlen = AWLEN;
    if (WVALID !== 1'b0) early_w = 1'b1;
    @(negedge clk);
    if (WVALID !== 1'b0) early_w = 1'b1;
    AWREADY = 1'b1;
    #1 if (WVALID !== 1'b0) early_w = 1'b1;
    @(negedge clk);
    AWREADY = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      wr_data = 32'hA000_0000 + b;
      if (b == 0) begin
        wstrb0 = WSTRB;
        repeat (w_delay) begin
          WREADY = 1'b0;
          #1 if (wr_pop === 1'b1) pops++;
          @(negedge clk);
        end
      end
      WREADY = 1'b1;
      #1;
      if (wr_pop === 1'b1) pops++;
      if (WLAST === 1'b1) wlast_mask[b] = 1'b1;
      if (WDATA === 32'hA000_0000 + b) data_ok++;
      @(negedge clk);
      WREADY = 1'b0;
    end
    BVALID = 1'b1; BRESP = bresp;
    @(negedge clk);
    BVALID = 1'b0; BRESP = 2'b00;
    dn = done; er = err;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    checks++;
    if ({ARVALID, AWVALID, WVALID, RREADY, BREADY} !== 5'b0) begin
      errors++; $display("FAIL reset_valid_ready: got %b want 00000", {ARVALID, AWVALID, WVALID, RREADY, BREADY});
    end
    checks++;
    if ({done, err, wr_pop, rd_valid, rd_last} !== 5'b0) begin
      errors++; $display("FAIL reset_status: got %b want 00000", {done, err, wr_pop, rd_valid, rd_last});
    end
  endtask

  task automatic test_refill();
    logic acc, dn, er; logic [31:0] a; logic [7:0] len; logic [2:0] sz;
    int arv, cnt, last_at, dok;
    run_refill(32'h0000_1234, 4, -1, 3, acc, a, len, sz, arv, cnt, last_at, dok, dn, er);
    checks++; if (a !== 32'h1230) begin errors++; $display("FAIL refill_araddr: got %h want 00001230", a); end
    checks++; if (len !== 8'd3) begin errors++; $display("FAIL refill_arlen: got %0d want 3", len); end
    checks++; if (sz !== 3'd2) begin errors++; $display("FAIL refill_arsize: got %0d want 2", sz); end
    checks++; if (arv !== 4) begin errors++; $display("FAIL refill_arvalid_hold: got %0d want 4", arv); end
    checks++; if (cnt !== 4) begin errors++; $display("FAIL refill_rd_valid: got %0d want 4", cnt); end
    checks++; if (last_at !== 4) begin errors++; $display("FAIL refill_rd_last: got %0d want 4", last_at); end
    checks++; if (dok !== 4) begin errors++; $display("FAIL refill_rd_data: got %0d want 4", dok); end
    checks++; if ({dn, er} !== 2'b10) begin errors++; $display("FAIL refill_done_err: got %b want 10", {dn, er}); end
  endtask

  task automatic test_single_write();
    logic [31:0] a; logic [7:0] len, wl; logic [3:0] s; logic early, dn, er; int pops, dok;
    run_write(32'h0000_2006, 1'b0, 4'b1100, 1, 2, 2'b00, a, len, pops, wl, s, dok, early, dn, er);
    checks++; if (a !== 32'h2004) begin errors++; $display("FAIL single_awaddr: got %h want 00002004", a); end
    checks++; if (len !== 8'd0) begin errors++; $display("FAIL single_awlen: got %0d want 0", len); end
    checks++; if (s !== 4'b1100) begin errors++; $display("FAIL single_wstrb: got %b want 1100", s); end
    checks++; if (wl !== 8'b1) begin errors++; $display("FAIL single_wlast: got %b want 00000001", wl); end
    checks++; if (pops !== 1) begin errors++; $display("FAIL single_wr_pop: got %0d want 1", pops); end
    checks++; if ({dn, er} !== 2'b10) begin errors++; $display("FAIL single_done_err: got %b want 10", {dn, er}); end
  endtask

  task automatic test_line_write();
    logic [31:0] a; logic [7:0] len, wl; logic [3:0] s; logic early, dn, er; int pops, dok;
    run_write(32'h0000_3018, 1'b1, 4'b0001, 4, 0, 2'b00, a, len, pops, wl, s, dok, early, dn, er);
    checks++; if (a !== 32'h3010) begin errors++; $display("FAIL line_awaddr: got %h want 00003010", a); end
    checks++; if (len !== 8'd3) begin errors++; $display("FAIL line_awlen: got %0d want 3", len); end
    checks++; if (s !== 4'b1111) begin errors++; $display("FAIL line_wstrb: got %b want 1111", s); end
    checks++; if (wl !== 8'b1000) begin errors++; $display("FAIL line_wlast: got %b want 00001000", wl); end
    checks++; if (pops !== 4) begin errors++; $display("FAIL line_wr_pop: got %0d want 4", pops); end
    checks++; if (dok !== 4) begin errors++; $display("FAIL line_wdata: got %0d want 4", dok); end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL line_early_wvalid: got %b want 0", early); end
    checks++; if ({dn, er} !== 2'b10) begin errors++; $display("FAIL line_done_err: got %b want 10", {dn, er}); end
  endtask

  task automatic test_back_to_back();
    logic acc, dn, er; logic [31:0] a; logic [7:0] len; logic [2:0] sz;
    int arv, cnt, last_at, dok;
    run_refill(32'h0000_0104, 4, 1, 0, acc, a, len, sz, arv, cnt, last_at, dok, dn, er);
    checks++; if (cnt !== 4) begin errors++; $display("FAIL rresp_err_beats: got %0d want 4", cnt); end
    checks++; if ({dn, er} !== 2'b11) begin errors++; $display("FAIL rresp_err_done_err: got %b want 11", {dn, er}); end
    run_refill(32'h0000_0040, 4, -1, 0, acc, a, len, sz, arv, cnt, last_at, dok, dn, er);
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL b2b_req_ready: got %b want 1", acc); end
    checks++; if (a !== 32'h0040) begin errors++; $display("FAIL b2b_araddr: got %h want 00000040", a); end
    checks++; if ({dn, er} !== 2'b10) begin errors++; $display("FAIL b2b_done_err: got %b want 10", {dn, er}); end
  endtask

  task automatic test_beat_count();
    logic acc, dn, er; logic [31:0] a; logic [7:0] len; logic [2:0] sz;
    int arv, cnt, last_at, dok;
    run_refill(32'h0000_0200, 3, -1, 0, acc, a, len, sz, arv, cnt, last_at, dok, dn, er);
    checks++; if (last_at !== 3) begin errors++; $display("FAIL short_rd_last: got %0d want 3", last_at); end
    checks++; if ({dn, er} !== 2'b11) begin errors++; $display("FAIL short_done_err: got %b want 11", {dn, er}); end
    run_refill(32'h0000_0300, 5, -1, 1, acc, a, len, sz, arv, cnt, last_at, dok, dn, er);
    checks++; if (cnt !== 5) begin errors++; $display("FAIL long_rd_valid: got %0d want 5", cnt); end
    checks++; if ({dn, er} !== 2'b11) begin errors++; $display("FAIL long_done_err: got %b want 11", {dn, er}); end
  endtask

  task automatic test_bresp_error();
    logic [31:0] a; logic [7:0] len, wl; logic [3:0] s; logic early, dn, er; int pops, dok;
    run_write(32'h0000_4000, 1'b0, 4'b1111, 1, 0, 2'b11, a, len, pops, wl, s, dok, early, dn, er);
    checks++; if ({dn, er} !== 2'b11) begin errors++; $display("FAIL bresp_done_err: got %b want 11", {dn, er}); end
  endtask

  task automatic test_reset_mid_burst();
    int d0;
    req_valid = 1'b1; req_write = 1'b1; req_line = 1'b1; req_addr = 32'h0000_5000; req_strb = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    AWREADY = 1'b1;
    @(negedge clk);
    AWREADY = 1'b0;
    wr_data = 32'h5555_0000;
    WREADY = 1'b1;
    @(negedge clk);
    WREADY = 1'b0;
    d0 = done_cnt;
    checks++; if (WVALID !== 1'b1) begin errors++; $display("FAIL midrst_in_beat2: got %b want 1", WVALID); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({ARVALID, AWVALID, WVALID} !== 3'b0) begin
      errors++; $display("FAIL midrst_valids: got %b want 000", {ARVALID, AWVALID, WVALID});
    end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midrst_req_ready: got %b want 1", req_ready); end
    repeat (3) @(negedge clk);
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL midrst_no_done: got %0d want %0d", done_cnt, d0); end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_line = 1'b0;
    req_addr = '0; req_strb = '0; wr_data = '0;
    ARREADY = 1'b0; RID = '0; RDATA = '0; RRESP = '0; RLAST = 1'b0; RVALID = 1'b0;
    AWREADY = 1'b0; WREADY = 1'b0; BID = '0; BRESP = '0; BVALID = 1'b0;
    @(negedge clk);
    test_reset();
    test_refill();
    test_single_write();
    test_line_write();
    test_back_to_back();
    test_beat_count();
    test_bresp_error();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_cache_master_port.md
Name: axi_cache_master_port

Overview:
- Parametrised single-master AXI4 port between one L1 cache (instruction or data) and the bus.
- Serves one outstanding transaction at a time: line refill (INCR read burst), single-beat write-through store, or full-line write-back (INCR write burst).
- Checks burst beat count and response codes and reports errors.
- One instance per cache; it replaces per-cache ad hoc bus sequencing in the CPU wrapper.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be 32 or 64.
- ID_W, 4, AXI ID width.
- ID_VAL, 0, constant driven on ARID/AWID.
- LINE_WORDS, 4, beats per line; must be a power of 2, 2..16.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous active-high reset.
- req_valid, in, 1: cache request.
- req_ready, out, 1: port idle, request accepted on valid&&ready.
- req_write, in, 1: 1 means write, 0 means refill read.
- req_line, in, 1: write only; 1 means full-line burst, 0 means single beat.
- req_addr, in, ADDR_W: byte address.
- req_strb, in, DATA_W/8: byte enables for a single write, active-high.
- wr_data, in, DATA_W: current write beat.
- wr_pop, out, 1: wr_data consumed this cycle (equals W handshake).
- rd_data, out, DATA_W: refill beat (RDATA pass-through).
- rd_valid, out, 1: refill beat valid (equals R handshake).
- rd_last, out, 1: last refill beat.
- done, out, 1: one-cycle pulse at transaction end.
- err, out, 1: valid with done; any non-OKAY response or beat-count mismatch.
- ARID/ARADDR/ARLEN(8)/ARSIZE(3)/ARBURST(2)/ARVALID out, ARREADY in.
- RID/RDATA/RRESP/RLAST/RVALID in, RREADY out.
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID out, AWREADY in.
- WDATA/WSTRB/WLAST/WVALID out, WREADY in.
- BID/BRESP/BVALID in, BREADY out.

Behaviour:
- Reset (clk edge with rst=1): state=IDLE, all VALID/READY outputs, done, err, wr_pop, rd_valid and rd_last = 0, beat counter = 0. Reset mid-burst abandons the transaction with no done; the bus side is assumed reset together.
- States: IDLE, AR, R, AW, W, B.
- IDLE: req_ready=1. On req_valid, latch addr/write/line/strb. Next state is AR for a read, AW for a write. Nothing is issued in the acceptance cycle, so ARVALID or AWVALID rises the following cycle.
- Address alignment:
  - Read and line write: addr & ~(LINE_WORDS*DATA_W/8-1), LEN = LINE_WORDS-1.
  - Single write: addr & ~(DATA_W/8-1), LEN = 0.
  - SIZE = log2(DATA_W/8). BURST = 2'b01 (INCR) always.
- AR: ARVALID held with stable fields until ARREADY; then go to R.
- R: RREADY=1. On each R handshake, counter++.
  - Ends on the RLAST handshake: done=1 next cycle, return to IDLE.
  - err if any RRESP≠0, or RLAST arrives with counter≠LINE_WORDS-1.
  - If the counter reaches LINE_WORDS-1 without RLAST, keep accepting beats until RLAST and flag err. rd_data beyond the line is still presented; the cache ignores it.
- AW: AWVALID held until AWREADY, then W. W is never asserted before the AW handshake completes.
- W: WVALID=1, WDATA=wr_data.
  - WSTRB = req_strb for a single write, all ones for a line write.
  - WLAST=1 when counter==LEN. On each W handshake, counter++.
  - After the last beat handshake, go to B.
- B: BREADY=1. On B handshake: done pulse; err if BRESP≠0; go to IDLE.
- done/err are registered: asserted in the cycle after the final handshake, which is also the first IDLE cycle. req_ready=1 in that cycle, so back-to-back requests are allowed.
- Counter is cleared on acceptance. Width is log2(LINE_WORDS)+1 bits, and it saturates at max.
- rd_last = RLAST && RVALID.
- Ready outputs are deasserted outside their own state. VALID never drops before its handshake.

Test Plan:
- Refill read of 0x0000_1234, LINE_WORDS=4, ARREADY after 3 cycles, 4 OKAY beats → ARADDR=0x1230, ARLEN=3, ARSIZE=2; 4 rd_valid pulses, rd_last on beat 4; done=1, err=0 one cycle later.
- Single write to 0x0000_2006, req_strb=4'b1100, WREADY delayed 2 cycles → AWADDR=0x2004, AWLEN=0; WSTRB=1100, WLAST=1; exactly one wr_pop; done after B OKAY.
- Line write of 0x0000_3018 with wr_data beats A,B,C,D → AWADDR=0x3010, AWLEN=3; 4 wr_pop pulses; WLAST only on beat D; WVALID never asserted before the AW handshake.
- Refill where beat 2 returns RRESP=2'b10 → all 4 beats still forwarded; done with err=1. A following request is accepted in the done cycle.
- Refill where RLAST arrives on beat 3, and separately only on beat 5 → both cases end at RLAST with err=1; no hang.
- rst=1 asserted during W beat 2 → next cycle all VALIDs are 0, state IDLE, req_ready=1, no done pulse.
